// File: rtl/tt_um_rescobar226_door_plant_if.sv
// Pin bundle for the door plant. It groups the enable, the command inputs,
// the status outputs and the bidirectional pins. The controller side or the
// bench uses the master modport. The plant uses the slave modport.
interface tt_um_rescobar226_door_plant_if;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uo_out;
  logic [7:0] uio_in;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  modport master (
    output ena,
    output ui_in,
    output uio_in,
    input  uo_out,
    input  uio_out,
    input  uio_oe
  );

  modport slave (
    input  ena,
    input  ui_in,
    input  uio_in,
    output uo_out,
    output uio_out,
    output uio_oe
  );
endinterface

// File: rtl/tt_um_rescobar226_door_plant.sv
// Door mechanism plant emulator.
// The motor commands MA (open) and MC (close) move a position counter at a
// prescaled rate. The limit switches LA and LC are decoded from that position.
// Driving both motor commands at once latches FAULT. FAULT clears only on FCLR
// while both commands are released. A reversal goes through a fixed brake
// period before the door can move the other way.
// Optional feature macro: DOOR_PLANT_OBSTACLE_EN. When it is defined, OBST
// stalls a closing door. When it is undefined, OBST is ignored and STALL is 0.
module tt_um_rescobar226_door_plant #(
  parameter int TRAVEL    = 40,
  parameter int PRESCALE  = 1000,
  parameter int BRAKE_CYC = 8
) (
  input  logic clk,
  input  logic rst_n,
  tt_um_rescobar226_door_plant_if.slave bus
);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_OPENING = 3'd1,
    ST_CLOSING = 3'd2,
    ST_BRAKE   = 3'd3,
    ST_FAULT   = 3'd4
  } state_t;

  localparam logic [7:0]  TRAVEL_V   = 8'(TRAVEL);
  localparam logic [15:0] PRE_LAST   = 16'(PRESCALE - 1);
  localparam logic [7:0]  BRAKE_LAST = 8'(BRAKE_CYC - 1);

  state_t      state_q, state_d;
  logic [7:0]  pos_q, pos_d;
  logic [15:0] presc_q, presc_d;
  logic [7:0]  brake_q, brake_d;

  logic ma, mc, obst, fclr;
  logic stall;

  assign ma   = bus.ui_in[0];
  assign mc   = bus.ui_in[1];
  assign obst = bus.ui_in[2];
  assign fclr = bus.ui_in[7];

`ifdef DOOR_PLANT_OBSTACLE_EN
  // A closing door stalls while the obstacle input is high.
  assign stall = obst && (state_q == ST_CLOSING);

  logic unused_inputs;
  assign unused_inputs = ^{bus.ui_in[6:3], bus.uio_in};
`else
  // Without obstacle support the door never stalls.
  assign stall = 1'b0;

  logic unused_inputs;
  assign unused_inputs = ^{obst, bus.ui_in[6:3], bus.uio_in};
`endif

  // State register: state, position, prescaler and brake counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      pos_q   <= 8'd0;
      presc_q <= 16'd0;
      brake_q <= 8'd0;
    end else begin
      state_q <= state_d;
      pos_q   <= pos_d;
      presc_q <= presc_d;
      brake_q <= brake_d;
    end
  end

  // Next-state logic. The fault check comes first. Motion, endpoint and brake handling follow it.
  always_comb begin
    state_d = state_q;
    pos_d   = pos_q;
    presc_d = presc_q;
    brake_d = brake_q;
    if (bus.ena) begin
      if (ma && mc) begin
        state_d = ST_FAULT;
      end else begin
        case (state_q)
          ST_FAULT: begin
            // ma and mc are not both high on this branch.
            // Both must also be low before the fault clears.
            if (fclr && !ma && !mc) state_d = ST_IDLE;
          end
          ST_IDLE: begin
            if (ma && (pos_q < TRAVEL_V))   state_d = ST_OPENING;
            else if (mc && (pos_q != 8'd0)) state_d = ST_CLOSING;
          end
          ST_OPENING: begin
            if (mc) begin
              state_d = ST_BRAKE;
            end else if (!ma) begin
              state_d = ST_IDLE;
            end else if (presc_q == PRE_LAST) begin
              presc_d = 16'd0;
              if (pos_q != TRAVEL_V) pos_d = pos_q + 8'd1;
              if (pos_q + 8'd1 >= TRAVEL_V) state_d = ST_IDLE;
            end else begin
              presc_d = presc_q + 16'd1;
            end
          end
          ST_CLOSING: begin
            if (ma) begin
              state_d = ST_BRAKE;
            end else if (!mc) begin
              state_d = ST_IDLE;
            end else if (!stall) begin
              if (presc_q == PRE_LAST) begin
                presc_d = 16'd0;
                if (pos_q != 8'd0) pos_d = pos_q - 8'd1;
                if (pos_q <= 8'd1) state_d = ST_IDLE;
              end else begin
                presc_d = presc_q + 16'd1;
              end
            end
          end
          ST_BRAKE: begin
            if (brake_q == BRAKE_LAST) state_d = ST_IDLE;
            else                       brake_d = brake_q + 8'd1;
          end
          default: state_d = ST_IDLE;
        endcase
      end
      // Every state change starts the prescaler and the brake count fresh.
      if (state_d != state_q) begin
        presc_d = 16'd0;
        brake_d = 8'd0;
      end
    end
  end

  // Output decode from the registered state and position.
  always_comb begin
    bus.uo_out    = 8'd0;
    bus.uo_out[0] = (pos_q == TRAVEL_V);
    bus.uo_out[1] = (pos_q == 8'd0);
    bus.uo_out[2] = ((state_q == ST_OPENING) || (state_q == ST_CLOSING)) && !stall;
    bus.uo_out[3] = (state_q == ST_OPENING);
    bus.uo_out[4] = (state_q == ST_FAULT);
    bus.uo_out[5] = stall;
    bus.uio_out   = pos_q;
    bus.uio_oe    = 8'hFF;
  end

endmodule

// File: doc/tt_um_rescobar226_door_plant.md
# tt_um_rescobar226_door_plant

Door mechanism emulator: the plant side of the door-controller interface. It takes the motor commands MA (open) and MC (close) and moves a door position counter at a prescaled rate. From that position it drives the limit switches LA (fully open) and LC (fully closed) back to the controller. It also supports obstacle injection and detects illegal simultaneous motor drive, so the controller FSM can be exercised closed-loop on silicon or in simulation.

## Interface
Parameters:
- TRAVEL, default 40: position count from fully closed (0) to fully open (TRAVEL); range 2..255.
- PRESCALE, default 1000: clock cycles per one position step; range 1..65535.
- BRAKE_CYC, default 8: stopped cycles forced on direction reversal; range 1..255.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- ena  in  1  global enable; low freezes all state
- ui_in  in  8  [0] MA, [1] MC, [2] OBST obstacle, [7] FCLR fault clear, others unused
- uo_out  out  8  [0] LA, [1] LC, [2] MOVING, [3] DIR (1=opening), [4] FAULT, [5] STALL, [7:6] 0
- uio_in  in  8  unused
- uio_out  out  8  current position (zero-extended)
- uio_oe  out  8  constant 8'hFF

## Operation
- State register values: IDLE, OPENING, CLOSING, BRAKE, FAULT. Reset values: state IDLE, pos 0, prescaler 0, brake counter 0.
- Outputs after reset: LC=1, LA=0, MOVING=0, DIR=0, FAULT=0, STALL=0, uio_out=0.
- Outputs are decoded from registered state and position:
  - LA = (pos==TRAVEL); LC = (pos==0).
  - MOVING = state is OPENING or CLOSING with no stall.
  - DIR = 1 only in OPENING.
- Transitions are evaluated each cycle with ena=1. Priority is top first:
  - MA&MC=1 in any state -> FAULT.
  - FAULT -> IDLE only when FCLR=1 and MA=MC=0. Otherwise hold.
  - IDLE: MA=1 and pos<TRAVEL -> OPENING; MC=1 and pos>0 -> CLOSING.
  - OPENING: MC=1 -> BRAKE; MA=0 -> IDLE.
  - CLOSING: MA=1 -> BRAKE; MC=0 -> IDLE.
  - BRAKE: count BRAKE_CYC cycles, then -> IDLE. Commands are ignored while counting except the fault check.
- Prescaler:
  - Cleared on every state change.
  - Increments each cycle in OPENING/CLOSING while not stalled.
  - At PRESCALE-1 it wraps to 0 and pos steps ±1.
- Endpoint behaviour:
  - When pos reaches TRAVEL in OPENING, or 0 in CLOSING, the state goes to IDLE on the same step.
  - pos saturates; it never wraps.
  - A command held against an endpoint leaves the block in IDLE with the limit switch asserted.
- Obstacle:
  - OBST=1 in CLOSING sets STALL=1. The prescaler and pos hold while stalled.
  - Motion resumes, keeping its prescaler value, when OBST falls.
  - OBST is ignored in every other state.
- ena=0: all registers hold and outputs stay static.

## Timing
- Command to state change: 1 cycle. MA sampled high at edge N gives MOVING=1 after edge N.
- First position step occurs PRESCALE cycles after entering OPENING/CLOSING. Later steps follow every PRESCALE cycles.
- Full travel takes TRAVEL×PRESCALE cycles plus 1 cycle of command latency. LA rises the cycle pos becomes TRAVEL.
- Reversal dead time: exactly BRAKE_CYC cycles in BRAKE, then 1 cycle in IDLE, then the new direction.
- Fault detection:
  - FAULT=1 one cycle after MA&MC are sampled high.
  - pos is frozen at its current value; no half-step is applied.
- Reset asserted mid-motion returns the block immediately and asynchronously to closed, pos=0, with LC=1.

## Configuration
- DOOR_PLANT_OBSTACLE_EN defined: obstacle injection and STALL behave as described above.
- DOOR_PLANT_OBSTACLE_EN undefined:
  - The OBST input is ignored.
  - STALL (uo_out[5]) is tied to 0.
  - CLOSING never stalls.
  - No stall logic is synthesized.

## Test plan
All scenarios use PRESCALE=4, TRAVEL=10, BRAKE_CYC=3.
- Reset release with all inputs 0 -> LC=1, LA=0, uio_out=0, MOVING=0, FAULT=0.
- Open from closed: MA=1 held -> uio_out steps 1,2,…,10, one step every 4 cycles. LC falls at pos 1. LA=1 at pos 10, 41 cycles after MA. State returns to IDLE with MOVING=0 while MA is still high.
- Reversal at pos 5: MC=1 and MA=0 during OPENING -> 3 cycles BRAKE with MOVING=0, then IDLE, then CLOSING. pos decrements 4,3,…,0 and LC=1 at 0.
- Fault: MA=MC=1 for one cycle at pos 6 -> FAULT=1 next cycle and pos stays 6.
  - FCLR=1 with MA=1 -> no clear.
  - FCLR=1 with MA=MC=0 -> FAULT=0 next cycle.
- Obstacle (macro defined): OBST=1 for 20 cycles during CLOSING at pos 7 -> STALL=1, pos stays 7. After OBST falls, the remaining prescale count completes before pos=6.
- ena=0 for 10 cycles mid-opening -> uio_out and the prescaler are frozen, and motion resumes unchanged once ena=1.
